sr_readback: RTL and testbench

//  Readback end of the configuration shift-register link; the write controller drives din_sr.
//  On start: pulses load_sr to latch the SR contents, then generates DATA_WIDTH-1 clk_sr

---
 rtl/sr_pkg.sv | 21 ++
 rtl/sr_readback.sv | 99 +++++++++
 tb/tb_sr_readback.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the configuration shift-register link:
// default geometry and the one-hot readback state encoding.
package sr_pkg;

  localparam int SR_DATA_WIDTH = 170;
  localparam int SR_CNT_WIDTH  = 8;

  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    CAPTURE = 6'b000010,
    SETTLE  = 6'b000100,
    SAMPLE  = 6'b001000,
    HI      = 6'b010000,
    DONE    = 6'b100000
  } rb_state_e;

  function automatic logic rb_is_busy(rb_state_e s);
    return (s == CAPTURE) || (s == SETTLE) || (s == SAMPLE) || (s == HI);
  endfunction

endpackage

// File: rtl/sr_readback.sv
// Readback end of the configuration shift-register link: strobes load_sr, clocks the
// SR out one bit per two cycles and presents the captured word with a valid/ack handshake.
module sr_readback
  import sr_pkg::*;
#(
  parameter int DATA_WIDTH = SR_DATA_WIDTH,
  parameter int CNT_WIDTH  = SR_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  ack,
  input  logic                  dout_sr,
  output logic                  clk_sr,
  output logic                  load_sr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  busy
);

  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

  rb_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  clk_sr_q, clk_sr_d;
  logic                  load_sr_q, load_sr_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      dout_q    <= '0;
      clk_sr_q  <= 1'b0;
      load_sr_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      dout_q    <= dout_d;
      clk_sr_q  <= clk_sr_d;
      load_sr_q <= load_sr_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  // The bit counter and capture register advance alongside the state transitions.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dout_d  = dout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CAPTURE;
          dout_d  = '0;
        end
      end
      CAPTURE: state_d = SETTLE;
      SETTLE: begin
        state_d = SAMPLE;
        count_d = '0;
      end
      SAMPLE: begin
        dout_d[count_q] = dout_sr;
        if (count_q == LAST_BIT) begin
          state_d = DONE;
        end else begin
          count_d = count_q + 1'b1;
          state_d = HI;
        end
      end
      HI: state_d = SAMPLE;
      DONE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each one is a plain flop aligned with its state.
  always_comb begin
    load_sr_d = (state_d == CAPTURE);
    clk_sr_d  = (state_d == HI);
    valid_d   = (state_d == DONE);
    busy_d    = rb_is_busy(state_d);
  end

  assign clk_sr  = clk_sr_q;
  assign load_sr = load_sr_q;
  assign dout    = dout_q;
  assign valid   = valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_sr_readback.sv
// Bench for sr_readback: behavioural SR model on the serial side, scoreboard of expected
// words pushed at start and popped when valid rises.
module tb_sr_readback;

  localparam int DW      = 170;
  localparam int CW      = 8;
  localparam int TIMEOUT = 1000;
  localparam int VALID_LAT = 2 * DW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          ack = 1'b0;
  logic          dout_sr;
  logic          clk_sr, load_sr, valid, busy;
  logic [DW-1:0] dout;

  logic [DW-1:0] sr_model;
  logic [DW-1:0] sr_contents = '0;
  logic [DW-1:0] exp_q[$];

  int cyc = 0;
  int load_count = 0;
  int clk_sr_rises = 0;
  int tests_run = 0;
  int tests_failed = 0;

  sr_readback #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ack     (ack),
    .dout_sr (dout_sr),
    .clk_sr  (clk_sr),
    .load_sr (load_sr),
    .dout    (dout),
    .valid   (valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (load_sr) load_count <= load_count + 1;
  always @(posedge clk_sr) clk_sr_rises <= clk_sr_rises + 1;

  // SR model: parallel load on load_sr, shift toward bit 0 on each clk_sr rise.
  always @(posedge clk_sr or posedge load_sr) begin
    if (load_sr) sr_model <= sr_contents;
    else         sr_model <= sr_model >> 1;
  end
  assign dout_sr = sr_model[0];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW; i++) w[i] = 1'($urandom_range(0, 1));
    return w;
  endfunction

  task automatic start_readback(input logic [DW-1:0] word, output int edge0);
    sr_contents = word;
    exp_q.push_back(word);
    @(negedge clk);
    start = 1'b1;
    edge0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int v_cyc, output bit ok);
    ok = 1'b0;
    v_cyc = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        ok = 1'b1;
        v_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic wait_cycle(input int target);
    for (int i = 0; i < TIMEOUT && cyc < target; i++) @(negedge clk);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({clk_sr, load_sr, valid, busy} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000", {clk_sr, load_sr, valid, busy});
    end
    tests_run++;
    if (dout !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_dout: got %h expected 0", dout);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || load_sr !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_hold: got busy=%b load_sr=%b expected 0 0", busy, load_sr);
    end
  endtask

  // Runs one readback to DONE and checks word, latency and strobe counts; leaves DUT in DONE.
  task automatic run_and_check(input string name, input logic [DW-1:0] word);
    int e0, v;
    int l0, c0;
    bit ok;
    logic [DW-1:0] expw;
    l0 = load_count;
    c0 = clk_sr_rises;
    start_readback(word, e0);
    tests_run++;
    if (load_sr !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s_capture: got load_sr=%b busy=%b expected 1 1", name, load_sr, busy);
    end
    wait_valid(v, ok);
    expw = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL %s_timeout: valid not seen within %0d cycles", name, TIMEOUT);
    end else if (dout !== expw) begin
      tests_failed++;
      $display("[TB] FAIL %s_dout: got %h expected %h", name, dout, expw);
    end
    tests_run++;
    if (v - e0 != VALID_LAT) begin
      tests_failed++;
      $display("[TB] FAIL %s_latency: got %0d expected %0d", name, v - e0, VALID_LAT);
    end
    tests_run++;
    if (load_count - l0 != 1 || clk_sr_rises - c0 != DW - 1) begin
      tests_failed++;
      $display("[TB] FAIL %s_strobes: got load=%0d clk_sr=%0d expected 1 %0d",
               name, load_count - l0, clk_sr_rises - c0, DW - 1);
    end
  endtask

  task automatic test_single_bit();
    logic [DW-1:0] w;
    w = '0;
    w[0] = 1'b1;
    run_and_check("single_bit", w);
    pulse_ack();
  endtask

  task automatic test_ack_hold();
    logic [DW-1:0] w;
    logic [DW-1:0] held;
    w = {85{2'b10}};
    run_and_check("pattern", w);
    held = w;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests_run++;
      if (valid !== 1'b1 || dout !== held) begin
        tests_failed++;
        $display("[TB] FAIL hold_%0d: got valid=%b dout=%h expected 1 %h", i, valid, dout, held);
      end
    end
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    tests_run++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ack_release: got valid=%b busy=%b expected 0 0", valid, busy);
    end
  endtask

  task automatic test_ignored_start();
    int e0, v, l0;
    bit ok;
    logic [DW-1:0] expw;
    l0 = load_count;
    start_readback(rand_word(), e0);
    wait_cycle(e0 + 100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(v, ok);
    expw = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    tests_run++;
    if (!ok || dout !== expw || v - e0 != VALID_LAT) begin
      tests_failed++;
      $display("[TB] FAIL midstart: got ok=%b lat=%0d dout=%h expected 1 %0d %h",
               ok, v - e0, dout, VALID_LAT, expw);
    end
    @(negedge clk);
    start = 1'b1;
    ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ack = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || valid !== 1'b0 || load_count - l0 != 1) begin
      tests_failed++;
      $display("[TB] FAIL done_start: got busy=%b valid=%b loads=%0d expected 0 0 1",
               busy, valid, load_count - l0);
    end
  endtask

  task automatic test_async_abort();
    int e0;
    start_readback(rand_word(), e0);
    wait_cycle(e0 + 163);
    tests_run++;
    if (clk_sr !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL abort_pre: got clk_sr=%b busy=%b expected 1 1", clk_sr, busy);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({clk_sr, load_sr, valid, busy} !== 4'b0000 || dout !== '0) begin
      tests_failed++;
      $display("[TB] FAIL abort_async: got ctrl=%b dout=%h expected 0000 0",
               {clk_sr, load_sr, valid, busy}, dout);
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_and_check("post_abort", rand_word());
    pulse_ack();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words[3];
    logic [DW-1:0] expw;
    int e0, v, c0, l0, a_edge;
    bit ok;
    for (int k = 0; k < 3; k++) words[k] = rand_word();
    l0 = load_count;
    c0 = clk_sr_rises;
    sr_contents = words[0];
    exp_q.push_back(words[0]);
    @(negedge clk);
    start = 1'b1;
    e0 = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(v, ok);
      expw = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      tests_run++;
      if (!ok || dout !== expw) begin
        tests_failed++;
        $display("[TB] FAIL b2b_word%0d: got %h expected %h", k, dout, expw);
      end
      tests_run++;
      if (v - e0 != VALID_LAT || clk_sr_rises - c0 != DW - 1) begin
        tests_failed++;
        $display("[TB] FAIL b2b_timing%0d: got lat=%0d clk_sr=%0d expected %0d %0d",
                 k, v - e0, clk_sr_rises - c0, VALID_LAT, DW - 1);
      end
      if (k < 2) begin
        sr_contents = words[k+1];
        exp_q.push_back(words[k+1]);
      end else begin
        start = 1'b0;
      end
      ack = 1'b1;
      a_edge = cyc + 1;
      e0 = a_edge + 1;
      c0 = clk_sr_rises;
      @(negedge clk);
      ack = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL b2b_idle%0d: got busy=%b valid=%b expected 0 0", k, busy, valid);
      end
      if (k < 2) begin
        @(negedge clk);
        tests_run++;
        if (load_sr !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL b2b_restart%0d: got load_sr=%b expected 1", k, load_sr);
        end
      end
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (load_count - l0 != 3 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_loads: got loads=%0d busy=%b expected 3 0", load_count - l0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_ack_hold();
    test_ignored_start();
    test_async_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
